rs_age_select: RTL and testbench
================================

Name: rs_age_select

Overview:
- Parametrised ALU reservation station with age-ordered dispatch.
- Sits between decode/issue and the ALU: receives renamed operands, snoops CDB_PORTS result buses, dispatches the oldest ready entry via a valid/ready handshake.
- Differences from the current RS: configurable depth and CDB width; oldest-first selection instead of lowest index; dispatch locking while the ALU stalls; occupancy count; explicit flush.

Parameters:
- RS_BITS, 3, log2 of entry count; SIZE = 1<<RS_BITS.
- ROB_BITS, 4, width of RoB tag.
- CDB_PORTS, 2, number of broadcast result buses.
- XLEN, 32, operand width.
- OP_W, 6, encoded ALU op width.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; low freezes all state.
- flush  in  1  misprediction clear (RoB clear).
- issue_valid  in  1  issue request.
- issue_op  in  OP_W  ALU op.
- issue_dest  in  ROB_BITS  destination RoB tag.
- issue_imm  in  XLEN  immediate / precomputed A.
- issue_vj, issue_vk  in  XLEN  operand values.
- issue_qj, issue_qk  in  ROB_BITS  producer tags.
- issue_rdj, issue_rdk  in  1  1 = operand value valid.
- full  out  1  no free entry.
- count  out  RS_BITS+1  busy entry count.
- cdb_valid  in  CDB_PORTS  per-bus valid.
- cdb_id  in  CDB_PORTS*ROB_BITS  packed tags.
- cdb_value  in  CDB_PORTS*XLEN  packed values.
- ex_valid  out  1  dispatch request.
- ex_ready  in  1  ALU accepts.
- ex_op, ex_vj, ex_vk, ex_imm, ex_dest  out  OP_W/XLEN/XLEN/XLEN/ROB_BITS  dispatched fields.

Behaviour:
- Per-entry state: busy, op, vj, vk, qj, qk, rdj, rdk, imm, dest. Age matrix older[i][j] = 1 when entry j was issued before entry i.
- Reset or flush (sync; takes priority over everything): all busy = 0, age matrix = 0, lock = 0. Outputs: ex_valid = 0, full = 0, count = 0. An issue in the same cycle is dropped.
- rdy_in low: no state changes. Outputs reflect held state. A handshake in that cycle does not count.
- Issue: accepted when issue_valid && !full. full is computed from registered busy bits, so an entry freed in the same cycle is not reusable until the next cycle.
  - Allocates the lowest-index free entry i.
  - Sets row i of the age matrix = current busy vector and clears column i.
- Issue-time bypass: an operand with rdy = 0 whose q matches a valid CDB tag that cycle is captured as ready. Lowest bus index wins on duplicate tags.
- Wakeup: every busy entry with rdX = 0 and qX == cdb_id[p] && cdb_valid[p] captures the value next edge. Both operands may wake in the same cycle.
- Selection: ready(i) = busy && rdj && rdk. The chosen entry is the ready entry with no older ready entry; it is one-hot and unique.
- Dispatch FSM (IDLE/LOCKED):
  - IDLE: ex_valid = any ready; outputs come combinationally from the selected entry. If ex_valid && !ex_ready, latch the selected index and go to LOCKED.
  - LOCKED: outputs come from the latched index; ex_valid = 1 and is stable even if an older entry becomes ready. On ex_ready, return to IDLE.
- Handshake: ex_valid && ex_ready frees the entry at the next edge and clears its age column.
- Simultaneous issue + dispatch free + wakeup are all legal; count updates by +1, -1 or 0 accordingly.

Optional Feature:
- RS_PERF_EN defined: adds outputs perf_dispatched (32-bit) and perf_full_stall (32-bit).
  - perf_dispatched increments on each handshake.
  - perf_full_stall increments on each cycle with issue_valid && full.
  - Both counters clear on rst_in only, not on flush; they wrap at 2^32.
- RS_PERF_EN undefined: the ports and counters are absent.

Decomposition:
- Shared package (`const.v` defines): RS_BITS, RoB_BITS, XLEN, ALU op encodings (6'b111111 = JAL, low 2 bits = type).
- One sub-module: rs_age_picker. Inputs: SIZE-bit request vector and the age matrix. Outputs: one-hot grant, encoded index, any-valid.

Test Plan:
- Reset, then issue 3 entries (tags 1, 2, 3) with all operands ready, ex_ready = 1 → dispatch order 1, 2, 3 on consecutive cycles; count ends at 0.
- Issue tag 5 with qj = 4 not ready, then tag 6 ready; CDB tag 4 value 0x1234 on bus 1 → 6 dispatches first, 5 next with ex_vj = 0x1234.
- Hold ex_ready = 0 with tag 7 selected, then an older entry becomes ready → ex_dest stays 7 until the handshake.
- Fill all 8 entries → full = 1, a 9th issue is ignored and count = 8; one dispatch frees a slot, and the next issue succeeds a cycle later.
- Issue with qk = 2 while cdb_id[0] = 2 is valid in the same cycle → the entry is ready the next cycle; no lost wakeup.
- Flush asserted with 5 busy entries and issue_valid = 1 → next cycle count = 0, ex_valid = 0, and the dropped issue is not stored.

Source files
------------

// File: rtl/rs_age_select_pkg.sv
// rs_age_select_pkg: shared constants for the ALU reservation station.
//   - Default widths (entry index bits, RoB tag, operand, op, CDB bus count).
//   - ALU op encodings: 6'b111111 is JAL, low two bits give the op class.
//   - Dispatch FSM state type, also exported for debug.
package rs_age_select_pkg;

  localparam int DEF_RS_BITS   = 3;
  localparam int DEF_ROB_BITS  = 4;
  localparam int DEF_CDB_PORTS = 2;
  localparam int DEF_XLEN      = 32;
  localparam int DEF_OP_W      = 6;

  // ALU op encodings; the low two bits select the functional class.
  localparam logic [5:0] ALU_OP_ADD = 6'b000000;
  localparam logic [5:0] ALU_OP_SUB = 6'b000100;
  localparam logic [5:0] ALU_OP_AND = 6'b000001;
  localparam logic [5:0] ALU_OP_OR  = 6'b000101;
  localparam logic [5:0] ALU_OP_SLL = 6'b000010;
  localparam logic [5:0] ALU_OP_BEQ = 6'b000011;
  localparam logic [5:0] ALU_OP_JAL = 6'b111111;

  typedef enum logic [1:0] {
    ALU_TYPE_ARITH  = 2'b00,
    ALU_TYPE_LOGIC  = 2'b01,
    ALU_TYPE_SHIFT  = 2'b10,
    ALU_TYPE_BRANCH = 2'b11
  } alu_type_e;

  function automatic alu_type_e alu_op_type(input logic [5:0] op);
    return alu_type_e'(op[1:0]);
  endfunction

  // IDLE: dispatch follows the age picker. LOCKED: an offered entry is held
  // stable until the ALU accepts it.
  typedef enum logic {
    DISP_IDLE   = 1'b0,
    DISP_LOCKED = 1'b1
  } disp_state_e;

endpackage

// File: rtl/rs_age_picker.sv
// rs_age_picker: oldest-first arbiter over an age matrix.
//   req       in  SIZE       request vector (ready entries)
//   age       in  SIZE*SIZE  row i bit j set = entry j is older than entry i
//   grant     out SIZE       one-hot grant of the oldest requester
//   grant_idx out IDX_W      encoded grant index (0 when nothing requests)
//   any_valid out 1          at least one request
module rs_age_picker
  import rs_age_select_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int IDX_W = 3
) (
  input  logic [SIZE-1:0]      req,
  input  logic [SIZE*SIZE-1:0] age,
  output logic [SIZE-1:0]      grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 any_valid
);

  // An entry wins when no other requester is older than it. The age matrix
  // is a strict total order over busy entries, so exactly one requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = 0; i < SIZE; i++) begin
      grant[i] = req[i] && ((req & age[i*SIZE +: SIZE]) == '0);
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/rs_age_select.sv
// rs_age_select: ALU reservation station with age-ordered dispatch.
//   clk_in, rst_in (sync, active high), rdy_in (low freezes state), flush.
//   issue_*      : issue request; accepted when issue_valid && !full.
//   full, count  : no free entry / number of busy entries (registered).
//   cdb_*        : CDB_PORTS packed result buses snooped for wakeup/bypass.
//   ex_*         : dispatch to the ALU.
//   dbg_disp_state : dispatch FSM state (0 = IDLE, 1 = LOCKED).
//   Optional macro RS_PERF_EN adds perf_dispatched / perf_full_stall.
// Handshake: a transfer happens in a cycle where ex_valid && ex_ready and
// rdy_in is high; once ex_valid rises for an entry it stays high with the
// same payload until that transfer (or until reset/flush).
module rs_age_select
  import rs_age_select_pkg::*;
#(
  parameter int RS_BITS   = DEF_RS_BITS,
  parameter int ROB_BITS  = DEF_ROB_BITS,
  parameter int CDB_PORTS = DEF_CDB_PORTS,
  parameter int XLEN      = DEF_XLEN,
  parameter int OP_W      = DEF_OP_W
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          flush,
  input  logic                          issue_valid,
  input  logic [OP_W-1:0]               issue_op,
  input  logic [ROB_BITS-1:0]           issue_dest,
  input  logic [XLEN-1:0]               issue_imm,
  input  logic [XLEN-1:0]               issue_vj,
  input  logic [XLEN-1:0]               issue_vk,
  input  logic [ROB_BITS-1:0]           issue_qj,
  input  logic [ROB_BITS-1:0]           issue_qk,
  input  logic                          issue_rdj,
  input  logic                          issue_rdk,
  output logic                          full,
  output logic [RS_BITS:0]              count,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB_BITS-1:0] cdb_id,
  input  logic [CDB_PORTS*XLEN-1:0]     cdb_value,
  output logic                          ex_valid,
  input  logic                          ex_ready,
  output logic [OP_W-1:0]               ex_op,
  output logic [XLEN-1:0]               ex_vj,
  output logic [XLEN-1:0]               ex_vk,
  output logic [XLEN-1:0]               ex_imm,
  output logic [ROB_BITS-1:0]           ex_dest,
  output logic                          dbg_disp_state
`ifdef RS_PERF_EN
  ,
  output logic [31:0]                   perf_dispatched,
  output logic [31:0]                   perf_full_stall
`endif
);

  localparam int SIZE = 1 << RS_BITS;

  // Entry storage
  logic [SIZE-1:0]     busy_q, busy_d;
  logic [SIZE-1:0]     rdj_q, rdj_d;
  logic [SIZE-1:0]     rdk_q, rdk_d;
  logic [SIZE-1:0]     older_q [SIZE];
  logic [SIZE-1:0]     older_d [SIZE];
  logic [OP_W-1:0]     op_q    [SIZE];
  logic [OP_W-1:0]     op_d    [SIZE];
  logic [XLEN-1:0]     vj_q    [SIZE];
  logic [XLEN-1:0]     vj_d    [SIZE];
  logic [XLEN-1:0]     vk_q    [SIZE];
  logic [XLEN-1:0]     vk_d    [SIZE];
  logic [XLEN-1:0]     imm_q   [SIZE];
  logic [XLEN-1:0]     imm_d   [SIZE];
  logic [ROB_BITS-1:0] qj_q    [SIZE];
  logic [ROB_BITS-1:0] qj_d    [SIZE];
  logic [ROB_BITS-1:0] qk_q    [SIZE];
  logic [ROB_BITS-1:0] qk_d    [SIZE];
  logic [ROB_BITS-1:0] dest_q  [SIZE];
  logic [ROB_BITS-1:0] dest_d  [SIZE];

  logic [RS_BITS:0]    count_q, count_d;
  disp_state_e         state_q, state_d;
  logic [RS_BITS-1:0]  lock_idx_q, lock_idx_d;

  // Selection / control
  logic [SIZE-1:0]      ready_vec;
  logic [SIZE*SIZE-1:0] age_flat;
  logic [SIZE-1:0]      pick_grant;
  logic [RS_BITS-1:0]   pick_idx;
  logic                 pick_any;
  logic [RS_BITS-1:0]   disp_idx;
  logic [SIZE-1:0]      disp_onehot;
  logic [RS_BITS-1:0]   alloc_idx;
  logic                 issue_fire;
  logic                 disp_fire;

  // Returns {hit, value} for a tag on the CDB; the lowest bus index wins
  // when several buses carry the same tag.
  function automatic logic [XLEN:0] cdb_lookup(input logic [ROB_BITS-1:0] tag);
    logic [XLEN:0] res;
    res = '0;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (cdb_valid[p] && (cdb_id[p*ROB_BITS +: ROB_BITS] == tag)) begin
        res = {1'b1, cdb_value[p*XLEN +: XLEN]};
      end
    end
    return res;
  endfunction

  assign ready_vec = busy_q & rdj_q & rdk_q;

  always_comb begin
    age_flat = '0;
    for (int i = 0; i < SIZE; i++) begin
      age_flat[i*SIZE +: SIZE] = older_q[i];
    end
  end

  rs_age_picker #(
    .SIZE  (SIZE),
    .IDX_W (RS_BITS)
  ) u_picker (
    .req       (ready_vec),
    .age       (age_flat),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  // Lowest-index free entry, from registered busy bits only.
  always_comb begin
    alloc_idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = RS_BITS'(i);
    end
  end

  assign full  = &busy_q;
  assign count = count_q;

  // While locked the latched index drives the outputs, so a newly ready older
  // entry cannot change an offer the ALU has already seen.
  always_comb begin
    disp_idx    = pick_idx;
    disp_onehot = pick_grant;
    if (state_q == DISP_LOCKED) begin
      disp_idx    = lock_idx_q;
      disp_onehot = '0;
      disp_onehot[lock_idx_q] = 1'b1;
    end
  end

  // Reset and flush suppress the offer so no entry leaves during a clear.
  assign ex_valid = !rst_in && !flush && ((state_q == DISP_LOCKED) || pick_any);
  assign ex_op    = op_q[disp_idx];
  assign ex_vj    = vj_q[disp_idx];
  assign ex_vk    = vk_q[disp_idx];
  assign ex_imm   = imm_q[disp_idx];
  assign ex_dest  = dest_q[disp_idx];

  assign disp_fire  = ex_valid && ex_ready && rdy_in;
  assign issue_fire = issue_valid && !full && rdy_in && !flush && !rst_in;

  assign dbg_disp_state = state_q;

  // Dispatch FSM next state
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      DISP_IDLE: begin
        if (ex_valid && !ex_ready) begin
          state_d    = DISP_LOCKED;
          lock_idx_d = pick_idx;
        end
      end
      DISP_LOCKED: begin
        if (ex_ready) state_d = DISP_IDLE;
      end
      default: state_d = DISP_IDLE;
    endcase
    if (flush) begin
      state_d    = DISP_IDLE;
      lock_idx_d = '0;
    end
  end

  // Entry next state: wakeup, issue (with bypass), dispatch free, flush.
  always_comb begin
    logic [XLEN:0] hit;
    hit     = '0;
    busy_d  = busy_q;
    rdj_d   = rdj_q;
    rdk_d   = rdk_q;
    older_d = older_q;
    op_d    = op_q;
    vj_d    = vj_q;
    vk_d    = vk_q;
    imm_d   = imm_q;
    qj_d    = qj_q;
    qk_d    = qk_q;
    dest_d  = dest_q;
    count_d = count_q;

    for (int i = 0; i < SIZE; i++) begin
      if (busy_q[i] && !rdj_q[i]) begin
        hit = cdb_lookup(qj_q[i]);
        if (hit[XLEN]) begin
          rdj_d[i] = 1'b1;
          vj_d[i]  = hit[XLEN-1:0];
        end
      end
      if (busy_q[i] && !rdk_q[i]) begin
        hit = cdb_lookup(qk_q[i]);
        if (hit[XLEN]) begin
          rdk_d[i] = 1'b1;
          vk_d[i]  = hit[XLEN-1:0];
        end
      end
    end

    if (issue_fire) begin
      busy_d[alloc_idx] = 1'b1;
      op_d[alloc_idx]   = issue_op;
      dest_d[alloc_idx] = issue_dest;
      imm_d[alloc_idx]  = issue_imm;
      vj_d[alloc_idx]   = issue_vj;
      vk_d[alloc_idx]   = issue_vk;
      qj_d[alloc_idx]   = issue_qj;
      qk_d[alloc_idx]   = issue_qk;
      rdj_d[alloc_idx]  = issue_rdj;
      rdk_d[alloc_idx]  = issue_rdk;
      // Bypass a result broadcast in the issue cycle itself.
      if (!issue_rdj) begin
        hit = cdb_lookup(issue_qj);
        if (hit[XLEN]) begin
          rdj_d[alloc_idx] = 1'b1;
          vj_d[alloc_idx]  = hit[XLEN-1:0];
        end
      end
      if (!issue_rdk) begin
        hit = cdb_lookup(issue_qk);
        if (hit[XLEN]) begin
          rdk_d[alloc_idx] = 1'b1;
          vk_d[alloc_idx]  = hit[XLEN-1:0];
        end
      end
      // Newest entry: everything currently busy is older, nobody is younger.
      for (int r = 0; r < SIZE; r++) begin
        older_d[r][alloc_idx] = 1'b0;
      end
      older_d[alloc_idx] = busy_q;
    end

    // Applied after issue so an entry leaving this cycle is never recorded
    // as older than the new one.
    if (disp_fire) begin
      busy_d = busy_d & ~disp_onehot;
      for (int r = 0; r < SIZE; r++) begin
        older_d[r] = older_d[r] & ~disp_onehot;
      end
    end

    case ({issue_fire, disp_fire})
      2'b10:   count_d = count_q + (RS_BITS+1)'(1);
      2'b01:   count_d = count_q - (RS_BITS+1)'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      busy_d  = '0;
      count_d = '0;
      for (int r = 0; r < SIZE; r++) begin
        older_d[r] = '0;
      end
    end
  end

  // Control state; flush clears even while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q     <= '0;
      count_q    <= '0;
      state_q    <= DISP_IDLE;
      lock_idx_q <= '0;
      for (int r = 0; r < SIZE; r++) begin
        older_q[r] <= '0;
      end
    end else if (rdy_in || flush) begin
      busy_q     <= busy_d;
      count_q    <= count_d;
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      older_q    <= older_d;
    end
  end

  // Payload state; only meaningful while the matching busy bit is set.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in) begin
      rdj_q  <= rdj_d;
      rdk_q  <= rdk_d;
      op_q   <= op_d;
      vj_q   <= vj_d;
      vk_q   <= vk_d;
      imm_q  <= imm_d;
      qj_q   <= qj_d;
      qk_q   <= qk_d;
      dest_q <= dest_d;
    end
  end

`ifdef RS_PERF_EN
  logic [31:0] perf_disp_q, perf_disp_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_disp_d  = perf_disp_q;
    perf_stall_d = perf_stall_q;
    if (disp_fire) perf_disp_d = perf_disp_q + 32'd1;
    if (issue_valid && full) perf_stall_d = perf_stall_q + 32'd1;
  end

  // Cleared by reset only; flush leaves the statistics intact.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_disp_q  <= '0;
      perf_stall_q <= '0;
    end else if (rdy_in) begin
      perf_disp_q  <= perf_disp_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_dispatched = perf_disp_q;
  assign perf_full_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_rs_age_select.sv
// tb_rs_age_select: directed bench for rs_age_select with hand-computed
// expectations and a dispatch-order scoreboard.
module tb_rs_age_select;
  import rs_age_select_pkg::*;

  localparam int RS_BITS   = 3;
  localparam int ROB_BITS  = 4;
  localparam int CDB_PORTS = 2;
  localparam int XLEN      = 32;
  localparam int OP_W      = 6;

  // Clock / reset
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                          rst_in;
  logic                          rdy_in;
  logic                          flush;
  logic                          issue_valid;
  logic [OP_W-1:0]               issue_op;
  logic [ROB_BITS-1:0]           issue_dest;
  logic [XLEN-1:0]               issue_imm;
  logic [XLEN-1:0]               issue_vj;
  logic [XLEN-1:0]               issue_vk;
  logic [ROB_BITS-1:0]           issue_qj;
  logic [ROB_BITS-1:0]           issue_qk;
  logic                          issue_rdj;
  logic                          issue_rdk;
  logic                          full;
  logic [RS_BITS:0]              count;
  logic [CDB_PORTS-1:0]          cdb_valid;
  logic [CDB_PORTS*ROB_BITS-1:0] cdb_id;
  logic [CDB_PORTS*XLEN-1:0]     cdb_value;
  logic                          ex_valid;
  logic                          ex_ready;
  logic [OP_W-1:0]               ex_op;
  logic [XLEN-1:0]               ex_vj;
  logic [XLEN-1:0]               ex_vk;
  logic [XLEN-1:0]               ex_imm;
  logic [ROB_BITS-1:0]           ex_dest;
  logic                          dbg_disp_state;
`ifdef RS_PERF_EN
  logic [31:0]                   perf_dispatched;
  logic [31:0]                   perf_full_stall;
`endif

  rs_age_select #(
    .RS_BITS   (RS_BITS),
    .ROB_BITS  (ROB_BITS),
    .CDB_PORTS (CDB_PORTS),
    .XLEN      (XLEN),
    .OP_W      (OP_W)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_op       (issue_op),
    .issue_dest     (issue_dest),
    .issue_imm      (issue_imm),
    .issue_vj       (issue_vj),
    .issue_vk       (issue_vk),
    .issue_qj       (issue_qj),
    .issue_qk       (issue_qk),
    .issue_rdj      (issue_rdj),
    .issue_rdk      (issue_rdk),
    .full           (full),
    .count          (count),
    .cdb_valid      (cdb_valid),
    .cdb_id         (cdb_id),
    .cdb_value      (cdb_value),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_op          (ex_op),
    .ex_vj          (ex_vj),
    .ex_vk          (ex_vk),
    .ex_imm         (ex_imm),
    .ex_dest        (ex_dest),
    .dbg_disp_state (dbg_disp_state)
`ifdef RS_PERF_EN
    ,
    .perf_dispatched (perf_dispatched),
    .perf_full_stall (perf_full_stall)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [ROB_BITS-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_issue();
    issue_valid = 1'b0;
    issue_op    = '0;
    issue_dest  = '0;
    issue_imm   = '0;
    issue_vj    = '0;
    issue_vk    = '0;
    issue_qj    = '0;
    issue_qk    = '0;
    issue_rdj   = 1'b0;
    issue_rdk   = 1'b0;
  endtask

  task automatic clear_cdb();
    cdb_valid = '0;
    cdb_id    = '0;
    cdb_value = '0;
  endtask

  task automatic drive_issue(input logic [ROB_BITS-1:0] dest, input logic [XLEN-1:0] vj,
                             input logic [XLEN-1:0] vk, input logic [ROB_BITS-1:0] qj,
                             input logic [ROB_BITS-1:0] qk, input logic rdj, input logic rdk);
    issue_valid = 1'b1;
    issue_op    = ALU_OP_ADD;
    issue_dest  = dest;
    issue_imm   = {28'h0, dest};
    issue_vj    = vj;
    issue_vk    = vk;
    issue_qj    = qj;
    issue_qk    = qk;
    issue_rdj   = rdj;
    issue_rdk   = rdk;
  endtask

  task automatic drive_ready(input logic [ROB_BITS-1:0] dest, input logic [XLEN-1:0] vj);
    drive_issue(dest, vj, 32'h0, 4'h0, 4'h0, 1'b1, 1'b1);
  endtask

  task automatic drive_cdb(input int p, input logic [ROB_BITS-1:0] tag, input logic [XLEN-1:0] val);
    cdb_valid[p]                    = 1'b1;
    cdb_id[p*ROB_BITS +: ROB_BITS]  = tag;
    cdb_value[p*XLEN +: XLEN]       = val;
  endtask

  // Scoreboard: every accepted dispatch must match the next expected tag.
  always @(negedge clk_in) begin
    if (!rst_in && rdy_in && ex_valid && ex_ready) begin
      if (exp_q.size() == 0) chk("disp_unexpected", {60'h0, ex_dest}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("disp_order", {60'h0, ex_dest}, {60'h0, exp_q.pop_front()});
    end
  end

  initial begin
    clear_issue();
    clear_cdb();
    rst_in   = 1'b1;
    rdy_in   = 1'b1;
    flush    = 1'b0;
    ex_ready = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
    settle();
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_state", dbg_disp_state, 0);

    // Three ready entries drain in issue order, one per cycle.
    ex_ready = 1'b1;
    drive_ready(4'd1, 32'h11);
    settle();
    chk("s1_empty_valid", ex_valid, 0);
    tick();
    drive_ready(4'd2, 32'h22);
    exp_q.push_back(4'd1);
    settle();
    chk("s1_dest1", ex_dest, 1);
    chk("s1_vj1", ex_vj, 32'h11);
    chk("s1_imm1", ex_imm, 32'h1);
    chk("s1_op1", ex_op, ALU_OP_ADD);
    chk("s1_count1", count, 1);
    tick();
    drive_ready(4'd3, 32'h33);
    exp_q.push_back(4'd2);
    settle();
    chk("s1_dest2", ex_dest, 2);
    chk("s1_count2", count, 1);
    tick();
    clear_issue();
    exp_q.push_back(4'd3);
    settle();
    chk("s1_dest3", ex_dest, 3);
    tick();
    settle();
    chk("s1_count_end", count, 0);
    chk("s1_valid_end", ex_valid, 0);

    // Younger ready entry overtakes a waiting one; both operands wake together.
    drive_issue(4'd5, 32'h0, 32'h0, 4'd4, 4'd3, 1'b0, 1'b0);
    tick();
    drive_ready(4'd6, 32'h66);
    settle();
    chk("s2_wait_valid", ex_valid, 0);
    tick();
    clear_issue();
    drive_cdb(1, 4'd4, 32'h1234);
    drive_cdb(0, 4'd3, 32'h55);
    exp_q.push_back(4'd6);
    settle();
    chk("s2_first_dest", ex_dest, 6);
    tick();
    clear_cdb();
    exp_q.push_back(4'd5);
    settle();
    chk("s2_second_dest", ex_dest, 5);
    chk("s2_vj_wake", ex_vj, 32'h1234);
    chk("s2_vk_wake", ex_vk, 32'h55);
    tick();
    settle();
    chk("s2_valid_end", ex_valid, 0);

    // A stalled offer stays on tag 7 even after older tag 8 becomes ready.
    ex_ready = 1'b0;
    drive_issue(4'd8, 32'h0, 32'h0, 4'd9, 4'd0, 1'b0, 1'b1);
    tick();
    drive_ready(4'd7, 32'h77);
    tick();
    clear_issue();
    drive_cdb(0, 4'd9, 32'h99);
    settle();
    chk("s3_offer_valid", ex_valid, 1);
    chk("s3_offer_dest", ex_dest, 7);
    tick();
    clear_cdb();
    settle();
    chk("s3_lock_dest", ex_dest, 7);
    chk("s3_lock_state", dbg_disp_state, 1);
    tick();
    ex_ready = 1'b1;
    exp_q.push_back(4'd7);
    settle();
    chk("s3_hs_dest", ex_dest, 7);
    tick();
    exp_q.push_back(4'd8);
    settle();
    chk("s3_older_dest", ex_dest, 8);
    chk("s3_older_vj", ex_vj, 32'h99);
    tick();
    ex_ready = 1'b0;
    settle();
    chk("s3_count_end", count, 0);

    // Fill all eight entries; full blocks a ninth issue until a slot frees.
    for (int k = 0; k < 8; k++) begin
      drive_issue(4'(8 + k), 32'h0, 32'h0, (k == 0) ? 4'd13 : 4'd14, 4'd0, 1'b0, 1'b1);
      tick();
    end
    clear_issue();
    settle();
    chk("s4_full", full, 1);
    chk("s4_count8", count, 8);
    drive_ready(4'd4, 32'h44);
    tick();
    clear_issue();
    settle();
    chk("s4_ninth_dropped", count, 8);
    chk("s4_none_ready", ex_valid, 0);
    drive_cdb(0, 4'd13, 32'hAB);
    tick();
    clear_cdb();
    ex_ready = 1'b1;
    drive_ready(4'd4, 32'h44);
    exp_q.push_back(4'd8);
    settle();
    chk("s4_disp_dest", ex_dest, 8);
    chk("s4_full_same_cycle", full, 1);
    tick();
    ex_ready = 1'b0;
    settle();
    chk("s4_freed_full", full, 0);
    chk("s4_freed_count", count, 7);
    tick();
    clear_issue();
    settle();
    chk("s4_refill_count", count, 8);
    chk("s4_refill_full", full, 1);
    chk("s4_refill_dest", ex_dest, 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    chk("s4_flush_count", count, 0);
    chk("s4_flush_valid", ex_valid, 0);

    // Issue-time bypass: bus 0 wins over bus 1 for the same tag.
    ex_ready = 1'b1;
    drive_issue(4'd1, 32'h10, 32'h0, 4'd0, 4'd2, 1'b1, 1'b0);
    drive_cdb(0, 4'd2, 32'hBEEF);
    drive_cdb(1, 4'd2, 32'hDEAD);
    tick();
    clear_issue();
    clear_cdb();
    exp_q.push_back(4'd1);
    settle();
    chk("s5_bypass_valid", ex_valid, 1);
    chk("s5_bypass_dest", ex_dest, 1);
    chk("s5_bypass_vk", ex_vk, 32'hBEEF);
    tick();
    settle();
    chk("s5_count_end", count, 0);

    // Flush with five busy entries drops the concurrent issue.
    ex_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_issue(4'(k + 1), 32'h0, 32'h0, 4'd14, 4'd0, 1'b0, 1'b1);
      tick();
    end
    clear_issue();
    settle();
    chk("s6_count5", count, 5);
    flush = 1'b1;
    drive_ready(4'd3, 32'h33);
    tick();
    flush = 1'b0;
    clear_issue();
    settle();
    chk("s6_flush_count", count, 0);
    chk("s6_flush_full", full, 0);
    chk("s6_flush_valid", ex_valid, 0);
    tick();
    settle();
    chk("s6_dropped_valid", ex_valid, 0);
    chk("s6_dropped_count", count, 0);

    // rdy_in low freezes issue and handshake.
    rdy_in = 1'b0;
    drive_ready(4'd3, 32'h33);
    tick();
    rdy_in = 1'b1;
    clear_issue();
    settle();
    chk("s7_frozen_issue", count, 0);
    drive_ready(4'd2, 32'h22);
    tick();
    clear_issue();
    settle();
    chk("s7_offer_dest", ex_dest, 2);
    chk("s7_count1", count, 1);
    tick();
    rdy_in   = 1'b0;
    ex_ready = 1'b1;
    tick();
    rdy_in   = 1'b1;
    ex_ready = 1'b0;
    settle();
    chk("s7_frozen_hs_count", count, 1);
    chk("s7_frozen_hs_valid", ex_valid, 1);
    ex_ready = 1'b1;
    exp_q.push_back(4'd2);
    tick();
    ex_ready = 1'b0;
    settle();
    chk("s7_count_end", count, 0);

`ifdef RS_PERF_EN
    chk("perf_dispatched", perf_dispatched, 10);
    chk("perf_full_stall", perf_full_stall, 2);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
